// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment display path: active-low glyph table
// and the output register state type.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low patterns, bit6=g ... bit0=a, indexed by hex value
    localparam seg_t SEG_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {EMPTY, FULL} out_state_t;

endpackage

// File: rtl/seven_segment_lookup.sv
// Combinational inverse of the display encoder: segment pattern to nibble,
// with blank and error classification.
module seven_segment_lookup
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       blank,
    output logic       error
);

    always_comb begin
        digit = 4'd0;
        blank = 1'b0;
        error = 1'b0;
        if (seg == SEG_BLANK) begin
            blank = 1'b1;
        end else begin
            error = 1'b1;
            for (int i = 0; i < 16; i++) begin
                if (seg == SEG_GLYPH[i]) begin
                    digit = 4'(i);
                    error = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/seven_segment_monitor.sv
// Recovers the hex digit shown on an active-low 7-segment bus: synchronise,
// debounce, decode, and hand each new stable pattern out over valid/ready.
module seven_segment_monitor
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic [6:0] segments,
    input  logic       clear_overrun,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_blank,
    output logic       out_error,
    output logic       overrun
);

    localparam logic [7:0] STABLE_RUN = 8'(STABLE_CYCLES);
    localparam logic [1:0] WARM_DONE  = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0][6:0] sync_q;
    seg_t       seg_s;
    seg_t       seg_prev;
    seg_t       last_reported;
    logic [7:0] run;
    logic [7:0] run_next;
    logic [1:0] warm;
    logic       reported_any;
    logic       report;
    logic [3:0] dec_digit;
    logic       dec_blank;
    logic       dec_error;
    out_state_t state;

    assign seg_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync_q <= {SYNC_STAGES{SEG_BLANK}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], segments};
        end
    end

    // Reset values in the synchroniser are not real samples, so the run
    // counter is held at zero until the chain has been refilled from the bus.
    always_comb begin
        if (warm != WARM_DONE) begin
            run_next = 8'd0;
        end else if (seg_s != seg_prev) begin
            run_next = 8'd1;
        end else if (run >= STABLE_RUN) begin
            run_next = STABLE_RUN;
        end else begin
            run_next = run + 8'd1;
        end
        report = (run_next == STABLE_RUN) &&
                 (!reported_any || (seg_s != last_reported));
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            warm          <= 2'd0;
            run           <= 8'd0;
            seg_prev      <= SEG_BLANK;
            last_reported <= SEG_BLANK;
            reported_any  <= 1'b0;
        end else begin
            if (warm != WARM_DONE) begin
                warm <= warm + 2'd1;
            end
            run      <= run_next;
            seg_prev <= seg_s;
            if (report) begin
                last_reported <= seg_s;
                reported_any  <= 1'b1;
            end
        end
    end

    seven_segment_lookup lookup (
        .seg   (seg_s),
        .digit (dec_digit),
        .blank (dec_blank),
        .error (dec_error)
    );

    // A report always loads; setting overrun is written last so it beats a clear.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_digit <= 4'd0;
            out_blank <= 1'b0;
            out_error <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (clear_overrun) begin
                overrun <= 1'b0;
            end
            if (report) begin
                out_digit <= dec_digit;
                out_blank <= dec_blank;
                out_error <= dec_error;
            end
            case (state)
                EMPTY: begin
                    if (report) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (report) begin
                        if (!out_ready) begin
                            overrun <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Self-checking bench for seven_segment_monitor: scoreboard of expected
// events popped on each accepted handshake, plus latency and flag checks.
module tb_seven_segment_monitor;

    typedef struct packed {
        logic [3:0] digit;
        logic       blank;
        logic       error;
    } ev_t;

    logic       clk = 1'b0;
    logic       nReset;
    logic [6:0] segments;
    logic       clear_overrun;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_blank;
    logic       out_error;
    logic       overrun;

    int  checks = 0;
    int  errors = 0;
    int  events = 0;
    ev_t sb[$];

    seven_segment_monitor #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .nReset        (nReset),
        .segments      (segments),
        .clear_overrun (clear_overrun),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_digit     (out_digit),
        .out_blank     (out_blank),
        .out_error     (out_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input bit push,
                                 input logic [3:0] digit, input logic blank,
                                 input logic error);
        ev_t e;
        segments = seg;
        if (push) begin
            e.digit = digit;
            e.blank = blank;
            e.error = error;
            sb.push_back(e);
        end
    endtask

    // Every accepted handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nReset && out_valid && out_ready) begin
            events++;
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                checkOutput("ev_digit", 32'(out_digit), 32'(e.digit));
                checkOutput("ev_blank", 32'(out_blank), 32'(e.blank));
                checkOutput("ev_error", 32'(out_error), 32'(e.error));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nReset        = 1'b0;
        segments      = 7'h30;
        clear_overrun = 1'b0;
        out_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid",   32'(out_valid), 32'd0);
        checkOutput("rst_digit",   32'(out_digit), 32'd0);
        checkOutput("rst_blank",   32'(out_blank), 32'd0);
        checkOutput("rst_error",   32'(out_error), 32'd0);
        checkOutput("rst_overrun", 32'(overrun),   32'd0);

        // Digit 3 after reset: valid on the 6th edge, exactly one event
        nReset = 1'b1;
        applyStimulus(7'h30, 1'b1, 4'd3, 1'b0, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            checkOutput("t1_latency", 32'(out_valid), (e == 6) ? 32'd1 : 32'd0);
        end
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t1_one_event", 32'(events), 32'd1);

        // Short glitch back to the same pattern is not re-reported
        applyStimulus(7'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(7'h30, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t2_no_event", 32'(events), 32'd1);

        // Overwrite without ready sets overrun; clear pulse drops it
        out_ready = 1'b0;
        applyStimulus(7'h40, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t3_valid0",   32'(out_valid), 32'd1);
        checkOutput("t3_digit0",   32'(out_digit), 32'd0);
        checkOutput("t3_ovr0",     32'(overrun),   32'd0);
        applyStimulus(7'h08, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t3_validA",   32'(out_valid), 32'd1);
        checkOutput("t3_digitA",   32'(out_digit), 32'd10);
        checkOutput("t3_ovr_set",  32'(overrun),   32'd1);
        clear_overrun = 1'b1;
        @(posedge clk);
        #1;
        clear_overrun = 1'b0;
        checkOutput("t3_ovr_clr",  32'(overrun),   32'd0);
        applyStimulus(7'h08, 1'b1, 4'd10, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t3_events",   32'(events),    32'd2);
        checkOutput("t3_drained",  32'(out_valid), 32'd0);
        checkOutput("t3_hold",     32'(out_digit), 32'd10);

        // Unknown pattern flags error, then blank
        applyStimulus(7'h7E, 1'b1, 4'd0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(7'h7F, 1'b1, 4'd0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t4_events", 32'(events), 32'd4);

        // Ready on the same edge a new report loads: no overrun
        out_ready = 1'b0;
        applyStimulus(7'h24, 1'b1, 4'd2, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(7'h79, 1'b1, 4'd1, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_valid",   32'(out_valid), 32'd1);
        checkOutput("t5_digit",   32'(out_digit), 32'd1);
        checkOutput("t5_overrun", 32'(overrun),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_events",  32'(events),    32'd6);

        // Reset mid-episode while FULL; blank is reported after release
        out_ready = 1'b0;
        applyStimulus(7'h46, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t6_full", 32'(out_valid), 32'd1);
        applyStimulus(7'h12, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        nReset   = 1'b0;
        segments = 7'h7F;
        #1;
        checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_rst_digit", 32'(out_digit), 32'd0);
        checkOutput("t6_rst_blank", 32'(out_blank), 32'd0);
        checkOutput("t6_rst_error", 32'(out_error), 32'd0);
        checkOutput("t6_rst_ovr",   32'(overrun),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        nReset = 1'b1;
        applyStimulus(7'h7F, 1'b1, 4'd0, 1'b1, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            checkOutput("t6_latency", 32'(out_valid), (e == 6) ? 32'd1 : 32'd0);
        end
        checkOutput("t6_blank", 32'(out_blank), 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_events",   32'(events),    32'd7);
        checkOutput("sb_leftover", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
